axi_ddr_reg_slice: RTL and testbench
====================================

// Module: axi_ddr_reg_slice
// PURPOSE
//  Full five-channel AXI4 register slice between the address-remapping stage and the PS HP/DDR port.
//  Breaks every combinational valid/ready/payload path across the FPGA-fabric-to-PS boundary.
//  Full-throughput skid buffering with 1-cycle forward latency; no reordering, no payload modification.
// PARAMETERS
//  ADDR_W   32      AW/AR address width
//  DATA_W   64      W/R data width; WSTRB is DATA_W/8
//  ID_W     8       AW/AR/B/R ID width
//  BYPASS   5'b0    per-channel bypass {AW,W,B,AR,R}; bit=1 makes that channel a pure wire
// PORTS
//  clock     in   1   sole clock; all state on rising edge
//  reset     in   1   asynchronous, active-high reset
//  s_axi_aw* in/out  valid,ready,addr[ADDR_W],id[ID_W],len[8],size[3],burst[2],lock,cache[4],prot[3],qos[4]
//  s_axi_w*  in/out  valid,ready,data[DATA_W],strb[DATA_W/8],last
//  s_axi_b*  out/in  valid,ready,id[ID_W],resp[2]
//  s_axi_ar* in/out  same field set as AW
//  s_axi_r*  out/in  valid,ready,data[DATA_W],id[ID_W],resp[2],last
//  m_axi_*   mirror of s_axi_* with directions reversed; identical widths
// BEHAVIOUR
//  - Per channel, one skid buffer: main reg (drives downstream valid/payload) + skid reg.
//  - Forward latency 1 cycle: beat accepted at edge N is visible downstream after edge N.
//  - Upstream ready is registered: ready_q = !skid_valid; never combinational from downstream ready.
//  - Throughput: one beat/cycle sustained while downstream ready=1; no bubbles.
//  - States per channel: EMPTY(main=0,skid=0), ONE(main=1,skid=0), FULL(main=1,skid=1).
//    EMPTY: in_hs -> ONE.  ONE: in_hs&out_hs -> ONE; in_hs&!out_hs -> FULL; out_hs only -> EMPTY.
//    FULL: upstream ready=0; out_hs -> skid moves to main -> ONE.  No other transitions.
//  - Accepting into FULL is impossible (ready=0); simultaneous in/out in ONE replaces main, skid untouched.
//  - AXI stability: downstream valid never deasserts and payload never changes while valid&!ready.
//  - Order preserved per channel; channels fully independent (no AW/W coupling, no ID tracking).
//  - Payload regs: no reset (datapath); valid/ready regs: async reset.
//  - Reset values: all m_axi_*valid=0, all s_axi_*valid (B,R)=0, all *ready outputs=0.
//    Ready outputs rise on the first clock edge after reset deasserts (ready_q reset 0, sets next edge).
//  - Reset mid-burst: all buffered beats dropped instantly; no partial beat emitted; upstream
//    and downstream are expected to be reset together on this board.
//  - BYPASS bit=1: channel outputs = inputs combinationally, zero latency, no state.
// STRUCTURE
//  - Shared package/header: per-channel payload width localparams (AW_PL_W, W_PL_W, B_PL_W, R_PL_W)
//    and field-packing order {id,addr,len,size,burst,lock,cache,prot,qos}; pack/unpack defines.
//  - One sub-module: axi_skid_buffer #(W) (clock,reset,in_valid,in_ready,in_data,out_valid,
//    out_ready,out_data); top instantiates five, flattening each channel payload into a vector.
//  - Bypass via generate per channel around the skid-buffer instance.
// TESTING
//  - Reset: hold reset 5 cycles -> all valids 0, all readies 0; first edge after release -> readies 1.
//  - Streaming: AR valid every cycle, m ready=1, addr 0x1000_0000+8*i, 16 beats -> 16 beats out
//    in order, each 1 cycle later, zero gaps, s_axi_arready stays 1.
//  - Backpressure: m_axi_wready=0 while 3 W beats offered -> beat0 in main, beat1 in skid,
//    s_axi_wready=0 on cycle 2, beat2 held upstream; release -> 0,1,2 emitted in order, no loss/dup.
//  - Stability: random m ready toggling on R channel, 256 beats with rlast every 8th -> payload
//    constant while rvalid&!rready; scoreboard matches sequence and rlast positions.
//  - Reset mid-operation: assert reset with skid FULL on B -> m/s valids drop same cycle (async);
//    after release no stale B response (id 0x5A) appears.
//  - BYPASS=5'b00100 (B): bvalid/bid/bresp pass same cycle; other channels still show 1-cycle latency.

Source files
------------

// File: rtl/axi_ddr_reg_slice_pkg.sv
// axi_ddr_reg_slice_pkg: shared widths, payload packing sizes and skid-buffer states
package axi_ddr_reg_slice_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_e;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;
  localparam int ID_W_DEF = 8;
  // AW/AR payload packs as {id,addr,len,size,burst,lock,cache,prot,qos}
  function automatic int ax_pl_w(int addr_w, int id_w);
    return id_w + addr_w + 8 + 3 + 2 + 1 + 4 + 3 + 4;
  endfunction
  function automatic int w_pl_w(int data_w);
    return data_w + data_w / 8 + 1;
  endfunction
  function automatic int b_pl_w(int id_w);
    return id_w + 2;
  endfunction
  function automatic int r_pl_w(int data_w, int id_w);
    return data_w + id_w + 2 + 1;
  endfunction
  localparam int AW_PL_W = ax_pl_w(ADDR_W_DEF, ID_W_DEF);
  localparam int W_PL_W = w_pl_w(DATA_W_DEF);
  localparam int B_PL_W = b_pl_w(ID_W_DEF);
  localparam int R_PL_W = r_pl_w(DATA_W_DEF, ID_W_DEF);
endpackage

// File: rtl/axi_ddr_reg_slice_if.sv
// axi_ddr_reg_slice_if: five-channel AXI4 bundle with master/slave views
interface axi_ddr_reg_slice_if
  import axi_ddr_reg_slice_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ID_W = ID_W_DEF
);
  logic awvalid, awready, awlock;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0] awid;
  logic [7:0] awlen;
  logic [2:0] awsize, awprot;
  logic [1:0] awburst;
  logic [3:0] awcache, awqos;
  logic wvalid, wready, wlast;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic bvalid, bready;
  logic [ID_W-1:0] bid;
  logic [1:0] bresp;
  logic arvalid, arready, arlock;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0] arid;
  logic [7:0] arlen;
  logic [2:0] arsize, arprot;
  logic [1:0] arburst;
  logic [3:0] arcache, arqos;
  logic rvalid, rready, rlast;
  logic [DATA_W-1:0] rdata;
  logic [ID_W-1:0] rid;
  logic [1:0] rresp;
  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
    input awready,
    output wvalid, wdata, wstrb, wlast,
    input wready,
    input bvalid, bid, bresp,
    output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
    input arready,
    input rvalid, rdata, rid, rresp, rlast,
    output rready
  );
  modport slave (
    input awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
    output awready,
    input wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input bready,
    input arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
    output arready,
    output rvalid, rdata, rid, rresp, rlast,
    input rready
  );
endinterface

// File: rtl/axi_ddr_reg_slice_skid_buffer.sv
// axi_skid_buffer: two-entry skid buffer, registered valid/ready, one-cycle forward latency
module axi_skid_buffer
  import axi_ddr_reg_slice_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  skid_state_e state, nxt;
  logic [W-1:0] skid;
  logic in_hs, out_hs;
  assign in_hs = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;
  always_comb begin
    nxt = state == EMPTY ? (in_hs ? ONE : EMPTY) :
          state == ONE   ? (in_hs && !out_hs ? FULL : !in_hs && out_hs ? EMPTY : ONE) :
                           (out_hs ? ONE : FULL);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      out_valid <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      state <= nxt;
      out_valid <= nxt != EMPTY;
      in_ready <= nxt != FULL;
    end
  end
  // datapath carries no reset; valid gates everything downstream
  always_ff @(posedge clock) begin
    if (out_hs && state == FULL) out_data <= skid;
    else if (in_hs && (state == EMPTY || out_hs)) out_data <= in_data;
    if (in_hs && !out_hs && state == ONE) skid <= in_data;
  end
endmodule

// File: rtl/axi_ddr_reg_slice.sv
// axi_ddr_reg_slice: five-channel AXI4 register slice, each channel a skid buffer or a bypass wire
module axi_ddr_reg_slice
  import axi_ddr_reg_slice_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ID_W = ID_W_DEF,
  parameter logic [4:0] BYPASS = 5'b0
) (
  input logic clock,
  input logic reset,
  axi_ddr_reg_slice_if.slave  s_axi,
  axi_ddr_reg_slice_if.master m_axi
);
  localparam int AXW = ax_pl_w(ADDR_W, ID_W);
  localparam int WW = w_pl_w(DATA_W);
  localparam int BW = b_pl_w(ID_W);
  localparam int RW = r_pl_w(DATA_W, ID_W);
  logic [AXW-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [WW-1:0] w_in, w_out;
  logic [BW-1:0] b_in, b_out;
  logic [RW-1:0] r_in, r_out;
  assign aw_in = {s_axi.awid, s_axi.awaddr, s_axi.awlen, s_axi.awsize, s_axi.awburst,
                  s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos};
  assign {m_axi.awid, m_axi.awaddr, m_axi.awlen, m_axi.awsize, m_axi.awburst,
          m_axi.awlock, m_axi.awcache, m_axi.awprot, m_axi.awqos} = aw_out;
  assign w_in = {s_axi.wdata, s_axi.wstrb, s_axi.wlast};
  assign {m_axi.wdata, m_axi.wstrb, m_axi.wlast} = w_out;
  assign b_in = {m_axi.bid, m_axi.bresp};
  assign {s_axi.bid, s_axi.bresp} = b_out;
  assign ar_in = {s_axi.arid, s_axi.araddr, s_axi.arlen, s_axi.arsize, s_axi.arburst,
                  s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos};
  assign {m_axi.arid, m_axi.araddr, m_axi.arlen, m_axi.arsize, m_axi.arburst,
          m_axi.arlock, m_axi.arcache, m_axi.arprot, m_axi.arqos} = ar_out;
  assign r_in = {m_axi.rdata, m_axi.rid, m_axi.rresp, m_axi.rlast};
  assign {s_axi.rdata, s_axi.rid, s_axi.rresp, s_axi.rlast} = r_out;
  if (BYPASS[4]) begin : g_aw
    assign aw_out = aw_in;
    assign m_axi.awvalid = s_axi.awvalid;
    assign s_axi.awready = m_axi.awready;
  end else begin : g_aw
    axi_skid_buffer #(.W(AXW)) u_skid (
      .clock, .reset,
      .in_valid(s_axi.awvalid), .in_ready(s_axi.awready), .in_data(aw_in),
      .out_valid(m_axi.awvalid), .out_ready(m_axi.awready), .out_data(aw_out)
    );
  end
  if (BYPASS[3]) begin : g_w
    assign w_out = w_in;
    assign m_axi.wvalid = s_axi.wvalid;
    assign s_axi.wready = m_axi.wready;
  end else begin : g_w
    axi_skid_buffer #(.W(WW)) u_skid (
      .clock, .reset,
      .in_valid(s_axi.wvalid), .in_ready(s_axi.wready), .in_data(w_in),
      .out_valid(m_axi.wvalid), .out_ready(m_axi.wready), .out_data(w_out)
    );
  end
  // B and R flow from the PS side back toward the fabric
  if (BYPASS[2]) begin : g_b
    assign b_out = b_in;
    assign s_axi.bvalid = m_axi.bvalid;
    assign m_axi.bready = s_axi.bready;
  end else begin : g_b
    axi_skid_buffer #(.W(BW)) u_skid (
      .clock, .reset,
      .in_valid(m_axi.bvalid), .in_ready(m_axi.bready), .in_data(b_in),
      .out_valid(s_axi.bvalid), .out_ready(s_axi.bready), .out_data(b_out)
    );
  end
  if (BYPASS[1]) begin : g_ar
    assign ar_out = ar_in;
    assign m_axi.arvalid = s_axi.arvalid;
    assign s_axi.arready = m_axi.arready;
  end else begin : g_ar
    axi_skid_buffer #(.W(AXW)) u_skid (
      .clock, .reset,
      .in_valid(s_axi.arvalid), .in_ready(s_axi.arready), .in_data(ar_in),
      .out_valid(m_axi.arvalid), .out_ready(m_axi.arready), .out_data(ar_out)
    );
  end
  if (BYPASS[0]) begin : g_r
    assign r_out = r_in;
    assign s_axi.rvalid = m_axi.rvalid;
    assign m_axi.rready = s_axi.rready;
  end else begin : g_r
    axi_skid_buffer #(.W(RW)) u_skid (
      .clock, .reset,
      .in_valid(m_axi.rvalid), .in_ready(m_axi.rready), .in_data(r_in),
      .out_valid(s_axi.rvalid), .out_ready(s_axi.rready), .out_data(r_out)
    );
  end
endmodule

// File: tb/tb_axi_ddr_reg_slice.sv
// tb_axi_ddr_reg_slice: random per-channel traffic against a depth-2 queue model, plus B-bypass instance
module tb_axi_ddr_reg_slice;
  localparam int AXW = 65;
  localparam int WW = 73;
  localparam int BW = 10;
  localparam int RW = 75;
  localparam int PW [5] = '{AXW, WW, BW, AXW, RW};
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  axi_ddr_reg_slice_if s [2] ();
  axi_ddr_reg_slice_if m [2] ();
  axi_ddr_reg_slice #(.BYPASS(5'b00000)) dut (.clock(clk), .reset(rst), .s_axi(s[0]), .m_axi(m[0]));
  axi_ddr_reg_slice #(.BYPASS(5'b00100)) dut_byp (.clock(clk), .reset(rst), .s_axi(s[1]), .m_axi(m[1]));
  // channel index: 0 AW, 1 W, 2 B, 3 AR, 4 R
  logic iv [5];
  logic rd [5];
  logic [127:0] id [5];
  logic ov [2][5];
  logic ir [2][5];
  logic [127:0] od [2][5];
  for (genvar k = 0; k < 2; k++) begin : g_io
    assign s[k].awvalid = iv[0];
    assign {s[k].awid, s[k].awaddr, s[k].awlen, s[k].awsize, s[k].awburst, s[k].awlock,
            s[k].awcache, s[k].awprot, s[k].awqos} = id[0][AXW-1:0];
    assign m[k].awready = rd[0];
    assign ov[k][0] = m[k].awvalid;
    assign ir[k][0] = s[k].awready;
    assign od[k][0] = 128'({m[k].awid, m[k].awaddr, m[k].awlen, m[k].awsize, m[k].awburst,
                            m[k].awlock, m[k].awcache, m[k].awprot, m[k].awqos});
    assign s[k].wvalid = iv[1];
    assign {s[k].wdata, s[k].wstrb, s[k].wlast} = id[1][WW-1:0];
    assign m[k].wready = rd[1];
    assign ov[k][1] = m[k].wvalid;
    assign ir[k][1] = s[k].wready;
    assign od[k][1] = 128'({m[k].wdata, m[k].wstrb, m[k].wlast});
    assign m[k].bvalid = iv[2];
    assign {m[k].bid, m[k].bresp} = id[2][BW-1:0];
    assign s[k].bready = rd[2];
    assign ov[k][2] = s[k].bvalid;
    assign ir[k][2] = m[k].bready;
    assign od[k][2] = 128'({s[k].bid, s[k].bresp});
    assign s[k].arvalid = iv[3];
    assign {s[k].arid, s[k].araddr, s[k].arlen, s[k].arsize, s[k].arburst, s[k].arlock,
            s[k].arcache, s[k].arprot, s[k].arqos} = id[3][AXW-1:0];
    assign m[k].arready = rd[3];
    assign ov[k][3] = m[k].arvalid;
    assign ir[k][3] = s[k].arready;
    assign od[k][3] = 128'({m[k].arid, m[k].araddr, m[k].arlen, m[k].arsize, m[k].arburst,
                            m[k].arlock, m[k].arcache, m[k].arprot, m[k].arqos});
    assign m[k].rvalid = iv[4];
    assign {m[k].rdata, m[k].rid, m[k].rresp, m[k].rlast} = id[4][RW-1:0];
    assign s[k].rready = rd[4];
    assign ov[k][4] = s[k].rvalid;
    assign ir[k][4] = m[k].rready;
    assign od[k][4] = 128'({s[k].rdata, s[k].rid, s[k].rresp, s[k].rlast});
  end
  logic [127:0] q [5][$];
  bit armed;
  bit ih [5];
  int vp [5];
  int rp [5];
  int mode [5];
  int seq [5];
  logic [127:0] fixv [5];
  int checks = 0;
  int failures = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] gen(int c);
    logic [127:0] r = {$urandom, $urandom, $urandom, $urandom};
    r &= (128'd1 << PW[c]) - 128'd1;
    if (mode[c] == 1) r = fixv[c];
    else if (mode[c] == 2) r = (128'(32'h1000_0000) + 128'(8 * seq[c])) << 25;
    else if (mode[c] == 3) r[0] = (seq[c] % 8 == 7);
    return r;
  endfunction
  task automatic drive();
    for (int c = 0; c < 5; c++) begin
      if (!iv[c] || ih[c]) begin
        iv[c] = int'($urandom_range(99)) < vp[c];
        id[c] = gen(c);
        if (iv[c]) seq[c]++;
      end
      rd[c] = int'($urandom_range(99)) < rp[c];
    end
  endtask
  task automatic check_all();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 5; c++) begin
        if (k == 1 && c == 2) continue;
        check($sformatf("d%0d_ch%0d_valid", k, c), 128'(ov[k][c]), 128'(q[c].size() > 0));
        check($sformatf("d%0d_ch%0d_ready", k, c), 128'(ir[k][c]), 128'(armed && q[c].size() < 2));
        if (q[c].size() > 0) check($sformatf("d%0d_ch%0d_data", k, c), od[k][c], q[c][0]);
      end
  endtask
  task automatic check_byp();
    check("byp_b_valid", 128'(ov[1][2]), 128'(iv[2]));
    check("byp_b_ready", 128'(ir[1][2]), 128'(rd[2]));
    check("byp_b_data", od[1][2], id[2]);
  endtask
  task automatic clear_model();
    armed = 0;
    for (int c = 0; c < 5; c++) begin
      q[c].delete();
      ih[c] = 0;
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    if (rst) clear_model();
    else begin
      for (int c = 0; c < 5; c++) begin
        bit oh;
        ih[c] = iv[c] && armed && q[c].size() < 2;
        oh = q[c].size() > 0 && rd[c];
        if (oh) void'(q[c].pop_front());
        if (ih[c]) q[c].push_back(id[c]);
      end
      armed = 1;
    end
    #1 check_all();
    drive();
    #1 check_byp();
  endtask
  task automatic set_all(input int v, input int r);
    for (int c = 0; c < 5; c++) begin
      vp[c] = v;
      rp[c] = r;
      mode[c] = 0;
    end
  endtask
  initial begin
    for (int c = 0; c < 5; c++) begin
      iv[c] = 0;
      rd[c] = 0;
      id[c] = '0;
      seq[c] = 0;
      fixv[c] = '0;
    end
    clear_model();
    set_all(0, 0);
    repeat (5) cycle();
    rst = 1'b0;
    #1 check_all();
    cycle();
    check("ready_after_release", 128'(ir[0][1]), 128'(1));
    vp[3] = 100;
    rp[3] = 100;
    mode[3] = 2;
    seq[3] = 0;
    repeat (16) cycle();
    vp[3] = 0;
    repeat (4) cycle();
    vp[1] = 100;
    rp[1] = 0;
    repeat (4) cycle();
    check("w_backpressure_ready", 128'(ir[0][1]), 128'(0));
    vp[1] = 0;
    rp[1] = 100;
    repeat (6) cycle();
    for (int c = 0; c < 5; c++) begin
      vp[c] = 30 + int'($urandom_range(70));
      rp[c] = 20 + int'($urandom_range(80));
    end
    repeat (300) cycle();
    set_all(80, 50);
    mode[4] = 3;
    seq[4] = 0;
    repeat (400) cycle();
    set_all(0, 100);
    repeat (4) cycle();
    vp[2] = 100;
    rp[2] = 0;
    mode[2] = 1;
    fixv[2] = 128'h168;
    repeat (4) cycle();
    check("b_full_ready", 128'(ir[0][2]), 128'(0));
    @(negedge clk);
    vp[2] = 0;
    mode[2] = 0;
    rst = 1'b1;
    for (int c = 0; c < 5; c++) iv[c] = 0;
    #1 clear_model();
    check_all();
    repeat (5) cycle();
    rst = 1'b0;
    rp[2] = 100;
    repeat (6) cycle();
    set_all(60, 60);
    repeat (200) cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
